luz_monitor: RTL and testbench

- Receive-side checker for the traffic-light sequencer. It consumes the three light outputs LUZ_ROJA, LUZ_VERDE and LUZ_AMARILLA.
- It decodes the current phase, counts how long each phase lasts, and counts completed cycles.
- It flags illegal encodings, illegal transitions, too-short phases and stuck phases.
- It sits beside the light controller in system and test benches. It acts as a self-checking sink.

---
 rtl/luz_pkg.sv | 67 ++++++
 rtl/luz_dwell_cnt.sv | 32 +++
 rtl/luz_monitor.sv | 188 ++++++++++++++++++
 tb/tb_luz_monitor.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/luz_pkg.sv
// Shared definitions for the traffic-light monitor: state encoding, decoded
// phase values, error codes, light codes and small decode helpers.
package luz_pkg;

  typedef enum logic [2:0] {
    IDLE,
    VERDE,
    AMARILLA,
    ROJA,
    FALLA
  } state_t;

  // Decoded phase presented on FASE.
  localparam logic [1:0] FASE_IDLE     = 2'b00;
  localparam logic [1:0] FASE_VERDE    = 2'b01;
  localparam logic [1:0] FASE_AMARILLA = 2'b10;
  localparam logic [1:0] FASE_ROJA     = 2'b11;

  // First-error codes presented on ERR_CODE.
  localparam logic [2:0] ERR_NONE   = 3'd0;
  localparam logic [2:0] ERR_ONEHOT = 3'd1;
  localparam logic [2:0] ERR_SEQ    = 3'd2;
  localparam logic [2:0] ERR_SHORT  = 3'd3;
  localparam logic [2:0] ERR_STUCK  = 3'd4;

  // Light codes, ordered {roja, amarilla, verde}.
  localparam logic [2:0] CODE_VERDE    = 3'b001;
  localparam logic [2:0] CODE_AMARILLA = 3'b010;
  localparam logic [2:0] CODE_ROJA     = 3'b100;

  // Phase state selected by a one-hot light code; IDLE for anything else.
  function automatic state_t code_to_state(input logic [2:0] code);
    state_t s;
    case (code)
      CODE_VERDE:    s = VERDE;
      CODE_AMARILLA: s = AMARILLA;
      CODE_ROJA:     s = ROJA;
      default:       s = IDLE;
    endcase
    return s;
  endfunction

  // The only phase that may legally follow the given phase.
  function automatic state_t next_phase(input state_t cur);
    state_t s;
    case (cur)
      VERDE:    s = AMARILLA;
      AMARILLA: s = ROJA;
      ROJA:     s = VERDE;
      default:  s = IDLE;
    endcase
    return s;
  endfunction

  // FASE value for a state; IDLE and FALLA both read as 00.
  function automatic logic [1:0] state_to_fase(input state_t cur);
    logic [1:0] f;
    case (cur)
      VERDE:    f = FASE_VERDE;
      AMARILLA: f = FASE_AMARILLA;
      ROJA:     f = FASE_ROJA;
      default:  f = FASE_IDLE;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/luz_dwell_cnt.sv
// Dwell counter: clear to 0, load to 1 on phase entry, increment while the
// phase holds. at_term flags that the count sits at the terminal value TERM.
module luz_dwell_cnt #(
  parameter int CNT_W = 8,
  parameter int TERM  = 199
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             load,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             at_term
);

  // Counter register; clear beats load, load beats increment.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments make every flop update from pre-edge values.
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= CNT_W'(1);
    end else if (inc) begin
      count <= count + CNT_W'(1);
    end
  end

  assign at_term = (count == CNT_W'(TERM));

endmodule

// File: rtl/luz_monitor.sv
// Receive-side checker for the traffic-light sequencer. Decodes the phase
// from the three lights, measures phase dwell, counts red-to-green cycles and
// latches the first protocol violation until CLR_ERR.
// Optional macro LUZ_SYNC_EN: pass each light through a 2-flop synchronizer
// before decode (input-to-FASE latency becomes 3 cycles).
module luz_monitor
  import luz_pkg::*;
#(
  parameter int CNT_W        = 8,
  parameter int MIN_VERDE    = 4,
  parameter int MIN_AMARILLA = 2,
  parameter int MIN_ROJA     = 4,
  parameter int MAX_DWELL    = 200
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             ENABLE,
  input  logic             CLR_ERR,
  input  logic             LUZ_ROJA,
  input  logic             LUZ_VERDE,
  input  logic             LUZ_AMARILLA,
  output logic [1:0]       FASE,
  output logic [CNT_W-1:0] DWELL,
  output logic [7:0]       CICLOS,
  output logic             ERROR,
  output logic [2:0]       ERR_CODE
);

  state_t           state, state_n;
  logic [2:0]       code_raw, code;
  logic [CNT_W-1:0] dwell;
  logic             dwell_last;
  logic             cnt_clear, cnt_load, cnt_inc;
  logic             fault, err_clear, cic_inc;
  logic [2:0]       fault_code;
  logic             one_hot;
  state_t           code_state;

  assign code_raw = {LUZ_ROJA, LUZ_AMARILLA, LUZ_VERDE};

`ifdef LUZ_SYNC_EN
  logic [2:0] sync_q1, sync_q2;

  // Two-stage synchronizer on each light before decode.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= code_raw;
      sync_q2 <= sync_q1;
    end
  end

  assign code = sync_q2;
`else
  assign code = code_raw;
`endif

  assign one_hot    = $onehot(code);
  assign code_state = code_to_state(code);

  // Minimum dwell required before leaving a phase.
  function automatic logic [CNT_W-1:0] min_dwell(input state_t cur);
    logic [CNT_W-1:0] m;
    case (cur)
      VERDE:    m = CNT_W'(MIN_VERDE);
      AMARILLA: m = CNT_W'(MIN_AMARILLA);
      ROJA:     m = CNT_W'(MIN_ROJA);
      default:  m = '0;
    endcase
    return m;
  endfunction

  // The count sits one below MAX_DWELL when the next hold would reach it.
  luz_dwell_cnt #(
    .CNT_W (CNT_W),
    .TERM  (MAX_DWELL - 1)
  ) u_dwell (
    .clk     (CLK),
    .rst_n   (RESET),
    .clear   (cnt_clear),
    .load    (cnt_load),
    .inc     (cnt_inc),
    .count   (dwell),
    .at_term (dwell_last)
  );

  // Phase state register.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state and control decode; violation checks in priority order
  // one-hot > sequence > short > stuck.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    state_n    = state;
    cnt_clear  = 1'b0;
    cnt_load   = 1'b0;
    cnt_inc    = 1'b0;
    fault      = 1'b0;
    fault_code = ERR_NONE;
    err_clear  = 1'b0;
    cic_inc    = 1'b0;

    case (state)
      IDLE: begin
        if (ENABLE && one_hot) begin
          state_n  = code_state;
          cnt_load = 1'b1;
        end
      end

      VERDE, AMARILLA, ROJA: begin
        if (!ENABLE) begin
          state_n   = IDLE;
          cnt_clear = 1'b1;
        end else if (!one_hot) begin
          fault      = 1'b1;
          fault_code = ERR_ONEHOT;
        end else if (code_state == state) begin
          if (dwell_last) begin
            fault      = 1'b1;
            fault_code = ERR_STUCK;
          end else begin
            cnt_inc = 1'b1;
          end
        end else if (code_state != next_phase(state)) begin
          fault      = 1'b1;
          fault_code = ERR_SEQ;
        end else if (dwell < min_dwell(state)) begin
          fault      = 1'b1;
          fault_code = ERR_SHORT;
        end else begin
          state_n  = code_state;
          cnt_load = 1'b1;
          cic_inc  = (state == ROJA);
        end
        if (fault) begin
          state_n = FALLA;
        end
      end

      FALLA: begin
        if (CLR_ERR) begin
          state_n   = IDLE;
          cnt_clear = 1'b1;
          err_clear = 1'b1;
        end
      end

      default: begin
        state_n   = IDLE;
        cnt_clear = 1'b1;
      end
    endcase
  end

  // First-error latch: loaded only on the entry into FALLA.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      ERR_CODE <= ERR_NONE;
    end else if (err_clear) begin
      ERR_CODE <= ERR_NONE;
    end else if (fault) begin
      ERR_CODE <= fault_code;
    end
  end

  // Completed red-to-green cycles, saturating at 255.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      CICLOS <= '0;
    end else if (cic_inc && (CICLOS != 8'hFF)) begin
      CICLOS <= CICLOS + 8'd1;
    end
  end

  assign FASE  = state_to_fase(state);
  assign ERROR = (state == FALLA);
  assign DWELL = dwell;

endmodule

// File: tb/tb_luz_monitor.sv
// Self-checking bench for luz_monitor: directed scenarios plus randomized
// light/enable/clear traffic, compared each cycle against a behavioural model
// that tracks phase number, dwell, cycle count and first error.
module tb_luz_monitor;

  localparam int CNT_W     = 8;
  localparam int MIN_V     = 4;
  localparam int MIN_A     = 2;
  localparam int MIN_R     = 4;
  localparam int MAX_DWELL = 200;

  localparam logic [2:0] C_R = 3'b100;
  localparam logic [2:0] C_A = 3'b010;
  localparam logic [2:0] C_V = 3'b001;

  logic             CLK = 1'b0;
  logic             RESET = 1'b1;
  logic             ENABLE = 1'b0;
  logic             CLR_ERR = 1'b0;
  logic             LUZ_ROJA = 1'b0;
  logic             LUZ_VERDE = 1'b0;
  logic             LUZ_AMARILLA = 1'b0;
  logic [1:0]       FASE;
  logic [CNT_W-1:0] DWELL;
  logic [7:0]       CICLOS;
  logic             ERROR;
  logic [2:0]       ERR_CODE;

  int    n_checks = 0;
  int    n_errors = 0;
  string ctx = "reset";

  // Model: phase 0 none, 1 green, 2 yellow, 3 red; fault overrides phase.
  int m_phase, m_dwell, m_cyc, m_err;
  bit m_fault;
`ifdef LUZ_SYNC_EN
  logic [2:0] m_pipe1, m_pipe2;
`endif

  luz_monitor #(
    .CNT_W        (CNT_W),
    .MIN_VERDE    (MIN_V),
    .MIN_AMARILLA (MIN_A),
    .MIN_ROJA     (MIN_R),
    .MAX_DWELL    (MAX_DWELL)
  ) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .ENABLE       (ENABLE),
    .CLR_ERR      (CLR_ERR),
    .LUZ_ROJA     (LUZ_ROJA),
    .LUZ_VERDE    (LUZ_VERDE),
    .LUZ_AMARILLA (LUZ_AMARILLA),
    .FASE         (FASE),
    .DWELL        (DWELL),
    .CICLOS       (CICLOS),
    .ERROR        (ERROR),
    .ERR_CODE     (ERR_CODE)
  );

  always #5 CLK = ~CLK;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_dwell = 0;
    m_cyc   = 0;
    m_err   = 0;
    m_fault = 1'b0;
`ifdef LUZ_SYNC_EN
    m_pipe1 = '0;
    m_pipe2 = '0;
`endif
  endtask

  function automatic int min_for(input int ph);
    case (ph)
      1:       return MIN_V;
      2:       return MIN_A;
      3:       return MIN_R;
      default: return 0;
    endcase
  endfunction

  task automatic raise(input int code);
    m_fault = 1'b1;
    m_err   = code;
  endtask

  // One rising edge of the monitor, expressed as the behavioural rules.
  task automatic model_edge(input logic [2:0] raw, input logic en, input logic clr);
    logic [2:0] c;
    int         ph;
    bit         one_hot;
`ifdef LUZ_SYNC_EN
    c       = m_pipe2;
    m_pipe2 = m_pipe1;
    m_pipe1 = raw;
`else
    c = raw;
`endif
    one_hot = ($countones(c) == 1);
    ph      = c[0] ? 1 : (c[1] ? 2 : (c[2] ? 3 : 0));
    if (m_fault) begin
      if (clr) begin
        m_fault = 1'b0;
        m_err   = 0;
        m_dwell = 0;
        m_phase = 0;
      end
    end else if (m_phase == 0) begin
      if (en && one_hot) begin
        m_phase = ph;
        m_dwell = 1;
      end
    end else if (!en) begin
      m_phase = 0;
      m_dwell = 0;
    end else if (!one_hot) begin
      raise(1);
    end else if (ph == m_phase) begin
      if (m_dwell + 1 == MAX_DWELL) raise(4);
      else m_dwell++;
    end else if (ph != (m_phase % 3) + 1) begin
      raise(2);
    end else if (m_dwell < min_for(m_phase)) begin
      raise(3);
    end else begin
      if (m_phase == 3 && m_cyc < 255) m_cyc++;
      m_phase = ph;
      m_dwell = 1;
    end
  endtask

  task automatic check_all();
    check({ctx, ".fase"},     int'(FASE),     m_fault ? 0 : m_phase);
    check({ctx, ".dwell"},    int'(DWELL),    m_dwell);
    check({ctx, ".ciclos"},   int'(CICLOS),   m_cyc);
    check({ctx, ".error"},    int'(ERROR),    int'(m_fault));
    check({ctx, ".err_code"}, int'(ERR_CODE), m_err);
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".fase"},     int'(FASE),     0);
    check({tag, ".dwell"},    int'(DWELL),    0);
    check({tag, ".ciclos"},   int'(CICLOS),   0);
    check({tag, ".error"},    int'(ERROR),    0);
    check({tag, ".err_code"}, int'(ERR_CODE), 0);
  endtask

  // Called 1 time unit after a rising edge; returns at the same offset.
  task automatic step(input logic [2:0] code, input logic en, input logic clr);
    {LUZ_ROJA, LUZ_AMARILLA, LUZ_VERDE} = code;
    ENABLE  = en;
    CLR_ERR = clr;
    @(posedge CLK);
    model_edge(code, en, clr);
    #1;
    check_all();
  endtask

  task automatic run(input logic [2:0] code, input int n);
    repeat (n) step(code, 1'b1, 1'b0);
  endtask

  // Reset asserted between edges: outputs must clear with no clock edge.
  task automatic async_reset();
    #3;
    RESET = 1'b0;
    #1;
    check_zero({ctx, ".async_rst"});
    model_reset();
    {LUZ_ROJA, LUZ_AMARILLA, LUZ_VERDE} = 3'b000;
    ENABLE  = 1'b0;
    CLR_ERR = 1'b0;
    @(posedge CLK);
    #1;
    RESET = 1'b1;
  endtask

  initial begin
    logic [2:0] cur;
    int         sel;
    logic       en;
    logic       clr;

    model_reset();
    #1 RESET = 1'b0;
    #2;
    check_zero("por");
    @(posedge CLK);
    #1;
    RESET = 1'b1;

    // Legal sequence with two completed cycles.
    ctx = "legal";
    run(C_R, 5); run(C_V, 6); run(C_A, 3); run(C_R, 5); run(C_V, 1);
`ifndef LUZ_SYNC_EN
    check("legal.end_error",  int'(ERROR),  0);
    check("legal.end_ciclos", int'(CICLOS), 2);
    check("legal.end_fase",   int'(FASE),   1);
    check("legal.end_dwell",  int'(DWELL),  1);
`endif

    // Skip green->red, then hold red; first error must persist.
    async_reset();
    ctx = "skip";
    run(C_R, 5); run(C_V, 6); run(C_R, 1);
`ifndef LUZ_SYNC_EN
    check("skip.error",    int'(ERROR),    1);
    check("skip.err_code", int'(ERR_CODE), 2);
    check("skip.fase",     int'(FASE),     0);
`endif
    run(C_R, 10);
    check("skip.held_err_code", int'(ERR_CODE), 2);

    // Too-short green, then a one-cycle clear.
    async_reset();
    ctx = "short";
    run(C_R, 5); run(C_V, 2); run(C_A, 1);
`ifndef LUZ_SYNC_EN
    check("short.err_code", int'(ERR_CODE), 3);
`endif
    step(C_A, 1'b1, 1'b1);
`ifndef LUZ_SYNC_EN
    check("short.clr_error",    int'(ERROR),    0);
    check("short.clr_err_code", int'(ERR_CODE), 0);
    check("short.clr_fase",     int'(FASE),     0);
`endif

    // Two lights at once beats the sequence error.
    async_reset();
    ctx = "onehot";
    run(C_R, 5); run(C_V, 3); run(3'b101, 1);
`ifndef LUZ_SYNC_EN
    check("onehot.err_code", int'(ERR_CODE), 1);
`endif
    run(3'b101, 2);
    step(3'b111, 1'b1, 1'b1);

    // Disable drops to idle; fault survives disable; clear wins over a violation.
    async_reset();
    ctx = "enable";
    run(C_R, 3);
    step(C_R, 1'b0, 1'b0);
    step(C_R, 1'b0, 1'b0);
    run(C_R, 2);
    run(C_V, 1);
    step(C_V, 1'b0, 1'b0);
`ifndef LUZ_SYNC_EN
    check("enable.fault_kept", int'(ERR_CODE), 3);
`endif
    run(C_V, 2);
    step(3'b111, 1'b1, 1'b1);
    step(3'b000, 1'b1, 1'b0);
`ifndef LUZ_SYNC_EN
    check("enable.clr_wins_error", int'(ERROR), 0);
    check("enable.clr_wins_fase",  int'(FASE),  0);
`endif

    // Stuck green: fault on the edge that would reach MAX_DWELL.
    async_reset();
    ctx = "stuck";
    run(C_V, MAX_DWELL - 1);
`ifndef LUZ_SYNC_EN
    check("stuck.pre_dwell", int'(DWELL),    MAX_DWELL - 1);
    check("stuck.pre_err",   int'(ERR_CODE), 0);
    run(C_V, 1);
    check("stuck.err_code",  int'(ERR_CODE), 4);
    check("stuck.dwell",     int'(DWELL),    MAX_DWELL - 1);
`endif
    run(C_V, 5);
    check("stuck.frozen_dwell", int'(DWELL), MAX_DWELL - 1);

    // Reset mid-red with one completed cycle, then restart.
    async_reset();
    ctx = "midrst";
    run(C_R, 5); run(C_V, 4); run(C_A, 2); run(C_R, 3);
`ifndef LUZ_SYNC_EN
    check("midrst.pre_dwell",  int'(DWELL),  3);
    check("midrst.pre_ciclos", int'(CICLOS), 1);
`endif
    async_reset();
    run(C_V, 4); run(C_A, 2);

    // Cycle counter saturation.
    async_reset();
    ctx = "sat";
    run(C_R, 4);
    for (int i = 0; i < 256; i++) begin
      run(C_V, 4); run(C_A, 2); run(C_R, 4);
    end
    check("sat.ciclos", int'(CICLOS), 255);
    check("sat.error",  int'(ERROR),  0);

    // Randomized traffic biased toward legal progress.
    async_reset();
    ctx = "random";
    cur = C_R;
    for (int i = 0; i < 3000; i++) begin
      sel = $urandom_range(0, 99);
      if (sel >= 78 && sel < 93) begin
        cur = ($countones(cur) == 1) ? {cur[1:0], cur[2]} : C_R;
      end else if (sel >= 93) begin
        cur = 3'($urandom_range(0, 7));
      end
      en  = ($urandom_range(0, 39) != 0);
      clr = ($urandom_range(0, 11) == 0);
      step(cur, en, clr);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
